// File: rtl/pb_alu_reg.sv
// pb_alu_reg: registered two-button AND/ADD unit with synchronised, debounced pushbuttons.
// Define PB_ALU_SAT_EN to make ADD saturate to all ones on overflow.
module pb_alu_reg #(
    parameter int WIDTH    = 4,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             not_LEFT_pushbutton,
    input  logic             not_RIGHT_pushbutton,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [1:0]       mode,
    output logic             mode_changed
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    typedef enum logic [1:0] {IDLE = 2'b00, AND_OP = 2'b01, ADD_OP = 2'b10} mode_t;
    mode_t state, state_next;
    logic [1:0] sync1, sync2, press;
    logic [WIDTH:0] sum, alu;
    always_ff @(posedge clk)
        if (reset) begin
            sync1 <= 2'b11;
            sync2 <= 2'b11;
        end else begin
            sync1 <= {not_RIGHT_pushbutton, not_LEFT_pushbutton};
            sync2 <= sync1;
        end
    // bit 0 is LEFT, bit 1 is RIGHT; a press is an accepted 1->0 flip of the level
    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [CW-1:0] cnt;
        logic level, flip;
        assign flip = sync2[i] != level && cnt == CW'(DEBOUNCE - 1);
        assign press[i] = flip && level;
        always_ff @(posedge clk)
            if (reset) begin
                cnt   <= '0;
                level <= 1'b1;
            end else if (sync2[i] == level) begin
                cnt <= '0;
            end else if (flip) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + 1'b1;
            end
    end
    always_comb state_next = press == 2'b11 ? IDLE : press[0] ? AND_OP : press[1] ? ADD_OP : state;
    always_ff @(posedge clk)
        if (reset) begin
            state        <= IDLE;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_next;
            mode_changed <= state_next != state;
        end
    assign mode = state;
    assign sum  = {1'b0, A} + {1'b0, B};
    always_comb begin
        alu = '0;
        if (state == AND_OP)
            alu = {1'b0, A & B};
        else if (state == ADD_OP)
`ifdef PB_ALU_SAT_EN
            alu = sum[WIDTH] ? '1 : sum;
`else
            alu = sum;
`endif
    end
    always_ff @(posedge clk)
        if (reset) begin
            result <= '0;
            carry  <= 1'b0;
        end else begin
            {carry, result} <= alu;
        end
endmodule
